qam_demod: RTL and testbench

QAM_DEMOD -- requirements
Module: qam_demod

---
 rtl/qam_demod.sv | 124 ++++++++++++
 tb/tb_qam_demod.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/qam_demod.sv
// Coherent QPSK demodulator: integrate-and-dump over a 128-clock carrier period,
// energy-based silence detection and a SEARCH/REST/ACTIVE frame tracker.
module qam_demod #(
   parameter logic [25:0] SILENCE_TH = 26'd262144,
   parameter logic [5:0]  FRAME_LEN  = 6'd32,
   parameter logic [4:0]  REST_LEN   = 5'd16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic signed [8:0] mod_in,
   input  logic signed [8:0] GetSin,
   input  logic signed [8:0] GetCos,
   output logic [6:0]        demod_read,
   output logic [1:0]        conv_out,
   output logic              conv_valid,
   output logic              frame_start,
   output logic              rest_active,
   output logic              frame_err,
   output logic [5:0]        sym_count
);

   typedef enum logic [1:0] {SEARCH, REST, ACTIVE} state_t;

   state_t             state;
   logic signed [8:0]  sin_d, cos_d;
   logic signed [17:0] p_i, p_q;
   logic signed [24:0] acc_i, acc_q, fin_i, fin_q;
   logic [24:0]        mag_i, mag_q;
   logic [25:0]        energy;
   logic               silent, decide, primed;
   logic [1:0]         sym_bits;

   assign p_i = 18'(mod_in) * 18'(cos_d);
   assign p_q = 18'(mod_in) * 18'(sin_d);

   assign fin_i = acc_i + 25'(p_i);
   assign fin_q = acc_q + 25'(p_q);

   assign mag_i  = fin_i[24] ? $unsigned(-fin_i) : $unsigned(fin_i);
   assign mag_q  = fin_q[24] ? $unsigned(-fin_q) : $unsigned(fin_q);
   assign energy = {1'b0, mag_i} + {1'b0, mag_q};
   assign silent = energy < SILENCE_TH;

   assign sym_bits = {fin_i[24], fin_q > 25'sd0};

   // The demod_read==0 right after reset closes no window, so it is not a decision.
   assign decide = (demod_read == 7'd0) && primed;

   always_ff @(posedge clk) begin
      if (reset) begin
         demod_read  <= '0;
         sin_d       <= '0;
         cos_d       <= '0;
         acc_i       <= '0;
         acc_q       <= '0;
         primed      <= 1'b0;
         state       <= SEARCH;
         conv_out    <= '0;
         conv_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         sym_count   <= '0;
         rest_active <= 1'b1;
      end else begin
         // NOTE: every state register here uses <= so all updates see pre-edge values.
         demod_read  <= demod_read + 7'd1;
         sin_d       <= GetSin;
         cos_d       <= GetCos;
         primed      <= 1'b1;
         conv_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;

         if (demod_read == 7'd0) begin
            acc_i <= '0;
            acc_q <= '0;
         end else begin
            acc_i <= fin_i;
            acc_q <= fin_q;
         end

         if (decide) begin
            case (state)
               SEARCH: begin
                  if (silent) state <= REST;
               end
               REST: begin
                  if (!silent) begin
                     state       <= ACTIVE;
                     rest_active <= 1'b0;
                     sym_count   <= 6'd1;
                     conv_valid  <= 1'b1;
                     frame_start <= 1'b1;
                     conv_out    <= sym_bits;
                  end
               end
               ACTIVE: begin
                  if (!silent) begin
                     conv_valid <= 1'b1;
                     conv_out   <= sym_bits;
                     // A full frame followed directly by data starts the next frame.
                     if (sym_count < FRAME_LEN) begin
                        sym_count <= sym_count + 6'd1;
                     end else begin
                        sym_count   <= 6'd1;
                        frame_start <= 1'b1;
                     end
                  end else begin
                     state       <= REST;
                     rest_active <= 1'b1;
                     sym_count   <= '0;
                     frame_err   <= (sym_count < FRAME_LEN);
                  end
               end
               default: begin
                  state       <= SEARCH;
                  rest_active <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qam_demod.sv
// Randomized bench for qam_demod: a behavioural QPSK modulator drives the DUT and a
// symbol-level frame model predicts every decision.
module tb_qam_demod;

   localparam int FL = 32;
   localparam real PI = 3.14159265358979;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic signed [8:0] mod_in = '0;
   logic signed [8:0] GetSin = '0;
   logic signed [8:0] GetCos = '0;
   logic [6:0]        demod_read;
   logic [1:0]        conv_out;
   logic              conv_valid, frame_start, rest_active, frame_err;
   logic [5:0]        sym_count;

   always #5 clk = ~clk;

   qam_demod dut (
      .clk         (clk),
      .reset       (reset),
      .mod_in      (mod_in),
      .GetSin      (GetSin),
      .GetCos      (GetCos),
      .demod_read  (demod_read),
      .conv_out    (conv_out),
      .conv_valid  (conv_valid),
      .frame_start (frame_start),
      .rest_active (rest_active),
      .frame_err   (frame_err),
      .sym_count   (sym_count)
   );

   typedef struct {
      logic [1:0] bits;
      int         amp;
   } sym_t;

   typedef enum {M_SEARCH, M_REST, M_ACTIVE} mstate_t;

   sym_t    tx_q[$];
   sym_t    cur_sym, dec_sym;
   bit      have_cur, dec_pending;
   int      ph, prev_mod;
   int      lut_c[128], lut_s[128];
   mstate_t m_state;
   int      m_cnt;
   logic [1:0] cycle_bits[4];
   int      n_checks = 0;
   int      n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   // Modulator output: (+/-cos +/-sin) at carrier amplitude amp, scaled down by 8.
   function automatic int modulate(input sym_t s, input int p);
      real th, v;
      int  isg, qsg;
      th  = 2.0 * PI * p / 128.0;
      isg = s.bits[1] ? -1 : 1;
      qsg = s.bits[0] ? 1 : -1;
      v   = s.amp * (isg * $cos(th) + qsg * $sin(th)) / 8.0;
      return int'(v);
   endfunction

   function automatic sym_t mk(input logic [1:0] b, input int a);
      sym_t s;
      s.bits = b;
      s.amp  = a;
      return s;
   endfunction

   task automatic drive();
      if (ph == 0) begin
         if (have_cur) begin
            dec_sym     = cur_sym;
            dec_pending = 1'b1;
         end
         cur_sym  = (tx_q.size() > 0) ? tx_q.pop_front() : mk(2'b00, 0);
         have_cur = 1'b1;
      end
      mod_in   = 9'(prev_mod);
      prev_mod = modulate(cur_sym, ph);
      GetCos   = 9'(lut_c[ph]);
      GetSin   = 9'(lut_s[ph]);
      ph       = (ph + 1) % 128;
   endtask

   task automatic observe();
      bit loud, e_valid, e_fs, e_err;
      check("demod_read", demod_read, ph);
      if (ph == 1 && dec_pending) begin
         dec_pending = 1'b0;
         loud    = dec_sym.amp >= 200;
         e_valid = 1'b0;
         e_fs    = 1'b0;
         e_err   = 1'b0;
         case (m_state)
            M_SEARCH: if (!loud) m_state = M_REST;
            M_REST: if (loud) begin
               m_state = M_ACTIVE; m_cnt = 1; e_valid = 1'b1; e_fs = 1'b1;
            end
            M_ACTIVE: if (loud) begin
               e_valid = 1'b1;
               if (m_cnt < FL) m_cnt++;
               else begin m_cnt = 1; e_fs = 1'b1; end
            end else begin
               e_err   = m_cnt < FL;
               m_state = M_REST;
               m_cnt   = 0;
            end
            default: m_state = M_SEARCH;
         endcase
         check("conv_valid", conv_valid, e_valid);
         check("frame_start", frame_start, e_fs);
         check("frame_err", frame_err, e_err);
         check("sym_count", sym_count, m_cnt);
         check("rest_active", rest_active, m_state != M_ACTIVE);
         if (e_valid) check("conv_out", conv_out, dec_sym.bits);
      end else begin
         check("no_pulse", {conv_valid, frame_start, frame_err}, 3'b000);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      observe();
      drive();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_demod_read", demod_read, 0);
      check("rst_conv_out", conv_out, 0);
      check("rst_pulses", {conv_valid, frame_start, frame_err}, 3'b000);
      check("rst_sym_count", sym_count, 0);
      check("rst_rest_active", rest_active, 1);
      reset       = 1'b0;
      ph          = 0;
      prev_mod    = 0;
      have_cur    = 1'b0;
      dec_pending = 1'b0;
      m_state     = M_SEARCH;
      m_cnt       = 0;
      tx_q.delete();
   endtask

   task automatic push_zero(input int n);
      for (int i = 0; i < n; i++) tx_q.push_back(mk(2'b00, 0));
   endtask

   task automatic push_rand(input int n, input int amp);
      for (int i = 0; i < n; i++) tx_q.push_back(mk(2'($urandom_range(0, 3)), amp));
   endtask

   initial begin
      for (int k = 0; k < 128; k++) begin
         lut_c[k] = int'(255.0 * $cos(2.0 * PI * k / 128.0));
         lut_s[k] = int'(255.0 * $sin(2.0 * PI * k / 128.0));
      end
      cycle_bits[0] = 2'b00;
      cycle_bits[1] = 2'b01;
      cycle_bits[2] = 2'b11;
      cycle_bits[3] = 2'b10;

      do_reset();
      // Rest, a cycling frame, a back-to-back random frame, a truncated frame,
      // weak symbols that must read as silence, then a frame cut by reset.
      push_zero(16);
      for (int i = 0; i < 32; i++) tx_q.push_back(mk(cycle_bits[i % 4], 255));
      push_rand(32, 255);
      push_zero(3);
      push_rand(20, 255);
      push_zero(3);
      push_rand(2, 40);
      push_zero(2);
      push_rand(10, 255);
      drive();
      repeat (115 * 128) cycle();
      while (ph != 64) cycle();
      @(negedge clk);
      observe();
      check("pre_reset_active", rest_active, 0);

      do_reset();
      push_zero(2);
      push_rand(32, 255);
      push_zero(2);
      drive();
      repeat (37 * 128 + 4) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
